// File: rtl/jtpang_bank_arb_if.sv
// Bank arbiter bus: four read banks, ROM download port, SDRAM command port.
// slave = arbiter side; master = requesters and memory controller side.
interface jtpang_bank_arb_if;
  logic        downloading;
  logic [3:0]  ba_rd;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [21:0] prog_addr;
  logic [1:0]  prog_ba;
  logic        prog_we, prog_rd;
  logic        prog_ack, prog_rdy;
  logic        mem_req;
  logic [1:0]  mem_ba;
  logic [21:0] mem_addr;
  logic        mem_wr;
  logic        mem_ack, mem_dst, mem_dok, mem_rdy;
  logic        busy, tout_err;

  modport slave (
    input  downloading, ba_rd,
    input  ba0_addr, ba1_addr, ba2_addr, ba3_addr,
    output ba_ack, ba_dst, ba_dok, ba_rdy,
    input  prog_addr, prog_ba, prog_we, prog_rd,
    output prog_ack, prog_rdy,
    output mem_req, mem_ba, mem_addr, mem_wr,
    input  mem_ack, mem_dst, mem_dok, mem_rdy,
    output busy, tout_err
  );

  modport master (
    output downloading, ba_rd,
    output ba0_addr, ba1_addr, ba2_addr, ba3_addr,
    input  ba_ack, ba_dst, ba_dok, ba_rdy,
    output prog_addr, prog_ba, prog_we, prog_rd,
    input  prog_ack, prog_rdy,
    input  mem_req, mem_ba, mem_addr, mem_wr,
    output mem_ack, mem_dst, mem_dok, mem_rdy,
    input  busy, tout_err
  );
endinterface

// File: rtl/jtpang_bank_arb.sv
// Four-bank SDRAM read arbiter with download port, bank-0 priority option
// and DATA-phase watchdog. Ports: clk, rst_n, bus (jtpang_bank_arb_if.slave).
module jtpang_bank_arb #(
  parameter bit BA0_PRIO = 1'b1,
  parameter int TOUT     = 63
) (
  input logic              clk,
  input logic              rst_n,
  jtpang_bank_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA
  } state_t;

  localparam logic [5:0] W_LIM = 6'(TOUT - 1);

  state_t      r_state, w_state_nx;
  logic [1:0]  r_ba, w_ba_nx;
  logic [21:0] r_addr, w_addr_nx;
  logic        r_wr, w_wr_nx;
  logic        r_prog, w_prog_nx;
  logic [1:0]  r_last, w_last_nx;
  logic [5:0]  r_wdog, w_wdog_nx;
  logic        r_tout, w_tout_nx;

  logic [1:0]  w_win, w_idx;
  logic [21:0] w_win_addr;
  logic [3:0]  w_sel;
  logic        w_ack, w_hit, w_done, w_data;

  // Round-robin scan from r_last+1; smallest offset is assigned last.
  always_comb begin
    w_win = 2'd0;
    w_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (bus.ba_rd[w_idx]) w_win = w_idx;
    end
    if (BA0_PRIO && bus.ba_rd[0]) w_win = 2'd0;
  end

  always_comb begin
    w_win_addr = bus.ba0_addr;
    unique case (1'b1)
      w_win == 2'd1: w_win_addr = bus.ba1_addr;
      w_win == 2'd2: w_win_addr = bus.ba2_addr;
      w_win == 2'd3: w_win_addr = bus.ba3_addr;
      default:       w_win_addr = bus.ba0_addr;
    endcase
  end

  assign w_sel  = 4'b0001 << r_ba;
  assign w_data = (r_state == DATA);
  assign w_ack  = (r_state == REQ) && bus.mem_ack;
  assign w_hit  = w_data && !bus.mem_rdy && (r_wdog == W_LIM);
  assign w_done = (w_ack && bus.mem_rdy) ||
                  (w_data && (bus.mem_rdy || w_hit));

  assign bus.mem_req  = (r_state == REQ);
  assign bus.mem_ba   = r_ba;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wr   = r_wr;
  assign bus.busy     = (r_state != IDLE);
  assign bus.tout_err = r_tout;

  assign bus.ba_ack   = (w_ack && !r_prog) ? w_sel : 4'd0;
  assign bus.prog_ack = w_ack && r_prog;
  assign bus.ba_dst   = (w_data && !r_prog && bus.mem_dst) ? w_sel : 4'd0;
  assign bus.ba_dok   = (w_data && !r_prog && bus.mem_dok) ? w_sel : 4'd0;
  assign bus.ba_rdy   = (w_done && !r_prog) ? w_sel : 4'd0;
  assign bus.prog_rdy = w_done && r_prog;

  always_comb begin
    w_state_nx = r_state;
    w_ba_nx    = r_ba;
    w_addr_nx  = r_addr;
    w_wr_nx    = r_wr;
    w_prog_nx  = r_prog;
    w_last_nx  = r_last;
    w_wdog_nx  = r_wdog;
    w_tout_nx  = r_tout | w_hit;
    unique case (r_state)
      IDLE: begin
        w_wdog_nx = 6'd0;
        if (bus.downloading) begin
          if (bus.prog_we || bus.prog_rd) begin
            w_ba_nx    = bus.prog_ba;
            w_addr_nx  = bus.prog_addr;
            w_wr_nx    = bus.prog_we;
            w_prog_nx  = 1'b1;
            w_state_nx = REQ;
          end
        end else if (|bus.ba_rd) begin
          w_ba_nx    = w_win;
          w_addr_nx  = w_win_addr;
          w_wr_nx    = 1'b0;
          w_prog_nx  = 1'b0;
          w_state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          w_wdog_nx  = 6'd0;
          w_state_nx = bus.mem_rdy ? IDLE : DATA;
          if (!r_prog) w_last_nx = r_ba;
        end
      end
      DATA: begin
        w_wdog_nx = r_wdog + 6'd1;
        if (bus.mem_rdy || w_hit) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ba    <= 2'd0;
      r_addr  <= 22'd0;
      r_wr    <= 1'b0;
      r_prog  <= 1'b0;
      r_last  <= 2'd3;
      r_wdog  <= 6'd0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ba    <= w_ba_nx;
      r_addr  <= w_addr_nx;
      r_wr    <= w_wr_nx;
      r_prog  <= w_prog_nx;
      r_last  <= w_last_nx;
      r_wdog  <= w_wdog_nx;
      r_tout  <= w_tout_nx;
    end
  end

endmodule

// File: tb/tb_jtpang_bank_arb.sv
// Randomized scoreboard bench for jtpang_bank_arb.
// Round-robin instance is fully checked; a bank-0 priority instance runs alongside.
module tb_jtpang_bank_arb;

  typedef struct {
    bit          prog;
    int          ba;
    logic [21:0] addr;
    bit          wr;
    int          ndst;
    int          ndok;
    bit          tout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtpang_bank_arb_if b();
  jtpang_bank_arb_if b1();

  jtpang_bank_arb #(.BA0_PRIO(1'b0), .TOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  jtpang_bank_arb #(.BA0_PRIO(1'b1), .TOUT(8)) dut_p (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t cur;
  bit active = 0;
  bit chk_next = 0;
  int cnt_dst, cnt_dok;
  int m_last;
  bit m_tout;
  logic [3:0] pend;
  logic [21:0] baddr [4];
  int p_grants = 0;

  assign b.ba0_addr = baddr[0];
  assign b.ba1_addr = baddr[1];
  assign b.ba2_addr = baddr[2];
  assign b.ba3_addr = baddr[3];
  assign b1.ba0_addr = 22'h000100;
  assign b1.ba1_addr = 22'h000111;
  assign b1.ba2_addr = 22'h000122;
  assign b1.ba3_addr = 22'h000133;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [4:0] vec(input exp_t e);
    return e.prog ? 5'b10000 : 5'(5'd1 << e.ba);
  endfunction

  // Reference arbitration: first requester after the last one granted.
  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spur();
    b.mem_dst = 1'($urandom);
    b.mem_dok = 1'($urandom);
    b.mem_rdy = 1'($urandom);
  endtask

  task automatic txn(input logic [3:0] nreq, input bit dl, input bit pwe,
                     input logic [1:0] pba, input logic [21:0] paddr,
                     input int lat, input int nd, input logic [7:0] dm,
                     input logic [7:0] km, input bit same, input bit to);
    exp_t e;
    int ncyc;
    int w;
    for (int i = 0; i < 4; i++)
      if (nreq[i] && !pend[i]) begin
        baddr[i] = 22'($urandom);
        pend[i] = 1'b1;
      end
    b.ba_rd = pend;
    b.downloading = dl;
    b.prog_ba = pba;
    b.prog_addr = paddr;
    b.prog_we = dl ? pwe : 1'($urandom);
    b.prog_rd = dl ? !pwe : 1'($urandom);
    e.prog = dl;
    if (dl) begin
      e.ba = int'(pba);
      e.addr = paddr;
      e.wr = pwe;
    end else begin
      w = pick(pend);
      e.ba = w;
      e.addr = baddr[w];
      e.wr = 1'b0;
      m_last = w;
    end
    ncyc = same ? 0 : (to ? 8 : nd + 1);
    e.ndst = 0;
    e.ndok = 0;
    if (!dl)
      for (int i = 0; i < ncyc - 1; i++) begin
        e.ndst += int'(dm[i]);
        e.ndok += int'(km[i]);
      end
    m_tout = m_tout | to;
    e.tout = m_tout;
    q.push_back(e);
    b.mem_ack = 1'b0;
    spur();
    w = 0;
    while (!b.mem_req && w < 20) begin
      step();
      spur();
      w++;
    end
    if (!b.mem_req) begin
      total++;
      bad++;
      $display("FAIL req_wait got=0 want=1 t=%0t", $time);
      return;
    end
    repeat (lat) begin
      step();
      spur();
    end
    b.mem_ack = 1'b1;
    b.mem_rdy = same;
    step();
    b.mem_ack = 1'b0;
    b.mem_rdy = 1'b0;
    b.mem_dst = 1'b0;
    b.mem_dok = 1'b0;
    if (dl) begin
      b.prog_we = 1'b0;
      b.prog_rd = 1'b0;
      if ($urandom % 2 == 0) b.downloading = 1'b0;
    end else begin
      pend[e.ba] = 1'b0;
      b.ba_rd = pend;
    end
    for (int i = 0; i < ncyc; i++) begin
      b.mem_dst = (i < ncyc - 1) ? dm[i] : 1'b0;
      b.mem_dok = (i < ncyc - 1) ? km[i] : 1'b0;
      b.mem_rdy = !to && (i == ncyc - 1);
      step();
    end
    b.mem_dst = 1'b0;
    b.mem_dok = 1'b0;
    b.mem_rdy = 1'b0;
  endtask

  // Monitor: pops an expectation on every accept pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_next) begin
        check("busy_after", b.busy, 0);
        check("tout_err", b.tout_err, cur.tout);
        chk_next = 0;
      end
      if ({b.prog_ack, b.ba_ack} != 5'd0) begin
        if (active || q.size() == 0) begin
          check("ack_unexp", {b.prog_ack, b.ba_ack}, 0);
        end else begin
          cur = q.pop_front();
          active = 1;
          cnt_dst = 0;
          cnt_dok = 0;
          check("ack_vec", {b.prog_ack, b.ba_ack}, vec(cur));
          check("mem_ba", b.mem_ba, cur.ba);
          check("mem_addr", b.mem_addr, cur.addr);
          check("mem_wr", b.mem_wr, cur.wr);
          check("mem_req", b.mem_req, 1);
        end
      end
      if (b.ba_dst != 4'd0) begin
        if (active && !cur.prog && b.ba_dst == vec(cur)[3:0]) cnt_dst++;
        else check("dst_unexp", b.ba_dst, 0);
      end
      if (b.ba_dok != 4'd0) begin
        if (active && !cur.prog && b.ba_dok == vec(cur)[3:0]) cnt_dok++;
        else check("dok_unexp", b.ba_dok, 0);
      end
      if ({b.prog_rdy, b.ba_rdy} != 5'd0) begin
        if (!active) begin
          check("rdy_unexp", {b.prog_rdy, b.ba_rdy}, 0);
        end else begin
          check("rdy_vec", {b.prog_rdy, b.ba_rdy}, vec(cur));
          check("dst_cnt", cnt_dst, cur.ndst);
          check("dok_cnt", cnt_dok, cur.ndok);
          active = 0;
          chk_next = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b1.ba_ack != 4'd0) begin
      p_grants++;
      check("prio_ack", b1.ba_ack, 4'b0001);
    end
  end

  initial begin
    #1000000;
    $display("FAIL sim_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    b.downloading = 0;
    b.ba_rd = 0;
    b.prog_addr = 0;
    b.prog_ba = 0;
    b.prog_we = 0;
    b.prog_rd = 0;
    b.mem_ack = 0;
    b.mem_dst = 0;
    b.mem_dok = 0;
    b.mem_rdy = 0;
    b1.downloading = 0;
    b1.ba_rd = 4'hF;
    b1.prog_addr = 0;
    b1.prog_ba = 0;
    b1.prog_we = 0;
    b1.prog_rd = 0;
    b1.mem_ack = 1;
    b1.mem_dst = 0;
    b1.mem_dok = 0;
    b1.mem_rdy = 1;
    for (int i = 0; i < 4; i++) baddr[i] = 22'd0;
    pend = 0;
    m_last = 3;
    m_tout = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", b.mem_req, 0);
    check("rst_ba", b.mem_ba, 0);
    check("rst_addr", b.mem_addr, 0);
    check("rst_wr", b.mem_wr, 0);
    check("rst_busy", b.busy, 0);
    check("rst_tout", b.tout_err, 0);
    check("rst_bank", {b.ba_ack, b.ba_dst, b.ba_dok, b.ba_rdy}, 0);
    check("rst_prog", {b.prog_ack, b.prog_rdy}, 0);
    @(negedge clk) rst_n = 1;

    txn(4'b0110, 0, 0, 2'd0, 22'd0, 1, 1, 8'h01, 8'h01, 0, 0);
    txn(4'b0000, 0, 0, 2'd0, 22'd0, 0, 2, 8'h03, 8'h02, 0, 0);
    txn(4'b0001, 1, 1, 2'd3, 22'h12345, 2, 2, 8'h03, 8'h03, 0, 0);
    txn(4'b0000, 0, 0, 2'd0, 22'd0, 0, 0, 8'h00, 8'h00, 1, 0);
    txn(4'b0100, 0, 0, 2'd0, 22'd0, 1, 3, 8'h01, 8'h06, 0, 0);
    txn(4'b1000, 0, 0, 2'd0, 22'd0, 0, 0, 8'h55, 8'h2A, 0, 1);

    repeat (300) begin
      bit dl, sm, to;
      logic [3:0] nr;
      dl = ($urandom % 5 == 0);
      nr = 4'($urandom);
      if (!dl && (pend | nr) == 4'd0) nr = 4'(4'd1 << ($urandom % 4));
      sm = ($urandom % 6 == 0);
      to = !sm && ($urandom % 12 == 0);
      txn(nr, dl, 1'($urandom), 2'($urandom), 22'($urandom),
          int'($urandom % 4), int'($urandom % 6), 8'($urandom),
          8'($urandom), sm, to);
    end

    b.ba_rd = 0;
    b.downloading = 0;
    repeat (2) step();
    check("drain_q", q.size(), 0);
    pend[2] = 1'b1;
    baddr[2] = 22'h2AAAA;
    b.ba_rd = pend;
    step();
    check("pre_rst_req", b.mem_req, 1);
    #1 rst_n = 0;
    #1;
    check("mid_rst_req", b.mem_req, 0);
    check("mid_rst_ack", b.ba_ack, 0);
    check("mid_rst_busy", b.busy, 0);
    check("mid_rst_tout", b.tout_err, 0);
    m_last = 3;
    m_tout = 0;
    pend = pend | 4'b1001;
    b.ba_rd = pend;
    @(negedge clk) rst_n = 1;
    txn(4'b0000, 0, 0, 2'd0, 22'd0, 1, 2, 8'h02, 8'h03, 0, 0);
    txn(4'b0000, 0, 0, 2'd0, 22'd0, 0, 1, 8'h01, 8'h00, 0, 0);

    b.ba_rd = 0;
    repeat (3) step();
    check("end_q", q.size(), 0);
    check("end_active", active, 0);
    check("prio_seen", p_grants > 10, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
